gnr_node_param: RTL and testbench
=================================

GNR_NODE_PARAM -- requirements
Module: gnr_node_param

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_COPIES, 2, number of independent state copies (>=2).
- STATE_W, 1, node state width in bits.
- DIV_W, 2, width of each per-copy update divider.
- STEP_W, 8, width of each per-copy load counter.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, synchronous active-high reset.
- reset_nos, in, 1, synchronous network re-initialise.
- init_state, in, STATE_W, value loaded into every copy on reset_nos.
- start_s, in, NUM_COPIES, per-copy step strobe.
- div_cfg, in, NUM_COPIES*DIV_W, per-copy divider D_k; copy k loads on every (D_k+1)-th strobe.
- next_in, in, NUM_COPIES*STATE_W, per-copy next-state value from the network logic.
- s, out reg, NUM_COPIES*STATE_W, per-copy current state.
- node_s, out, NUM_COPIES*STATE_W, equal to s (fan-out to neighbours).
- upd, out reg, NUM_COPIES, one-cycle pulse in the cycle after copy k loads next_in.
- steps, out reg, NUM_COPIES*STEP_W, per-copy load count.
- match, out, NUM_COPIES-1, bit k-1 high when s[k] equals s[0]; combinational from registers.

Function
REQ-003 Copy k SHALL hold a divider counter cnt_k of width DIV_W.
REQ-004 The priority order SHALL be rst, then reset_nos, then start_s[k].
REQ-005 On reset_nos, every copy SHALL load init_state, set cnt_k to D_k, clear steps_k, and clear upd_k.
REQ-006 When start_s[k] is high and cnt_k >= D_k, copy k SHALL perform all of the following:
- load next_in slice k into s[k];
- clear cnt_k;
- increment steps_k;
- assert upd_k in the next cycle.
REQ-007 When start_s[k] is high and cnt_k < D_k, copy k SHALL increment cnt_k and leave s[k] unchanged.
REQ-008 When start_s[k] is low, copy k SHALL hold s[k], cnt_k and steps_k, and SHALL drive upd_k low.
REQ-009 The load latency SHALL be one cycle: s[k] shows the new value in the cycle after the qualifying strobe edge.
REQ-010 Because the load test is >=, lowering D_k mid-run SHALL never stall the copy: the next strobe loads if cnt_k >= new D_k.
REQ-011 steps_k SHALL saturate at 2^STEP_W-1 and SHALL NOT wrap.
REQ-012 Copies SHALL be fully independent; simultaneous strobes on several copies SHALL each be handled per REQ-006/007 in the same cycle.
REQ-013 reset_nos asserted together with start_s SHALL discard the strobe.
REQ-014 With D_k=0, copy k SHALL load on every strobe; with D_k=1, after reset_nos the first strobe loads, the second skips, and the pattern alternates.

Reset
REQ-015 rst SHALL clear every s[k], cnt_k, steps_k and upd_k to 0; match SHALL then read all-ones.
REQ-016 After rst with D_k>0, the first D_k strobes SHALL be skipped before the first load.
REQ-017 rst asserted mid-operation SHALL take effect at the next edge and override reset_nos and any strobe.

Structure
REQ-018 Package gnr_pkg SHALL hold the default values of STATE_W, DIV_W and STEP_W and a function for slice indexing.
REQ-019 Per-copy logic SHALL be one sub-module, gnr_copy_slot, instantiated NUM_COPIES times by generate.
REQ-020 The top level SHALL hold only the generate loop, the slice mapping and the match comparators.

Verification
REQ-021 Bench configuration: NUM_COPIES=2, STATE_W=4, D=(1,0). Apply rst, then reset_nos with init_state=5, then strobe both copies every cycle with next_in=(9,9).
- Required: s = (5,5) after reset_nos.
- Copy 0 loads 9 one cycle after the first strobe; copy 1 also loads 9 one cycle after the first strobe.
- Subsequent loads on copy 0 occur on alternate strobes.
REQ-022 rst only, D0=2, strobes on copy 0 with next_in=3 -> s0 stays 0 for 2 strobes, loads 3 after the 3rd strobe, and upd0 pulses exactly once.
REQ-023 reset_nos and start_s asserted together -> s = init_state, no upd pulse, steps = 0.
REQ-024 STEP_W=2, D=0, 6 strobes -> steps goes 1, 2, 3, 3, 3, 3 (saturated).
REQ-025 D0 changed from 3 to 0 while cnt0=2 -> the next strobe loads.
REQ-026 s0=s1=7 gives match=1; loading copy 1 with 4 -> match=0 in the following cycle.

Source files
------------

// File: rtl/gnr_pkg.sv
// gnr_pkg: shared defaults and helpers for the gnr node slice.
//   DefStateW / DefDivW / DefStepW : default widths of node state, divider and load counter.
//   slice_lo()                     : low bit index of slice idx in a packed per-copy bus.
package gnr_pkg;

  localparam int unsigned DefStateW = 1;
  localparam int unsigned DefDivW   = 2;
  localparam int unsigned DefStepW  = 8;

  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/gnr_copy_slot.sv
// gnr_copy_slot: one independent state copy of a network node.
//   clk_i, rst_i   : clock, synchronous active-high reset (clears everything to 0)
//   reset_nos_i    : network re-initialise (load init_state_i, preload divider)
//   init_state_i   : state loaded on reset_nos_i
//   start_i        : step strobe
//   div_i          : divider D; a load happens when the divider count has reached D
//   next_i         : next-state value from the network logic
//   s_o            : current state
//   upd_o          : one-cycle pulse in the cycle after a load
//   steps_o        : saturating count of loads
module gnr_copy_slot #(
  parameter int unsigned StateW = 1,
  parameter int unsigned DivW   = 2,
  parameter int unsigned StepW  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              reset_nos_i,
  input  logic [StateW-1:0] init_state_i,
  input  logic              start_i,
  input  logic [DivW-1:0]   div_i,
  input  logic [StateW-1:0] next_i,
  output logic [StateW-1:0] s_o,
  output logic              upd_o,
  output logic [StepW-1:0]  steps_o
);

  logic [StateW-1:0] s_q, s_d;
  logic [DivW-1:0]   cnt_q, cnt_d;
  logic [StepW-1:0]  steps_q, steps_d;
  logic              upd_q, upd_d;

  always_comb begin
    s_d     = s_q;
    cnt_d   = cnt_q;
    steps_d = steps_q;
    upd_d   = 1'b0;
    if (reset_nos_i) begin
      // Preloading cnt with D makes the first strobe after re-initialise load.
      s_d     = init_state_i;
      cnt_d   = div_i;
      steps_d = '0;
    end else if (start_i) begin
      // >= rather than == so that lowering D mid-run cannot strand the counter above it.
      if (cnt_q >= div_i) begin
        s_d     = next_i;
        cnt_d   = '0;
        upd_d   = 1'b1;
        if (steps_q != {StepW{1'b1}}) begin
          steps_d = steps_q + StepW'(1);
        end
      end else begin
        // cnt_q < div_i here, so the increment cannot overflow.
        cnt_d = cnt_q + DivW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q     <= '0;
      cnt_q   <= '0;
      steps_q <= '0;
      upd_q   <= 1'b0;
    end else begin
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      upd_q   <= upd_d;
    end
  end

  assign s_o     = s_q;
  assign upd_o   = upd_q;
  assign steps_o = steps_q;

endmodule

// File: rtl/gnr_node_param.sv
// gnr_node_param: network node with NUM_COPIES independent state copies.
//   clk, rst    : clock, synchronous active-high reset
//   reset_nos   : network re-initialise; init_state is loaded into every copy
//   start_s     : per-copy step strobe
//   div_cfg     : per-copy divider D_k (copy k loads on every (D_k+1)-th strobe)
//   next_in     : per-copy next-state values
//   s / node_s  : per-copy current state (node_s is the neighbour fan-out copy)
//   upd         : per-copy load pulse, steps : per-copy saturating load count
//   match       : bit k-1 set when copy k equals copy 0
module gnr_node_param
  import gnr_pkg::*;
#(
  parameter int unsigned NUM_COPIES = 2,
  parameter int unsigned STATE_W    = DefStateW,
  parameter int unsigned DIV_W      = DefDivW,
  parameter int unsigned STEP_W     = DefStepW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          reset_nos,
  input  logic [STATE_W-1:0]            init_state,
  input  logic [NUM_COPIES-1:0]         start_s,
  input  logic [NUM_COPIES*DIV_W-1:0]   div_cfg,
  input  logic [NUM_COPIES*STATE_W-1:0] next_in,
  output logic [NUM_COPIES*STATE_W-1:0] s,
  output logic [NUM_COPIES*STATE_W-1:0] node_s,
  output logic [NUM_COPIES-1:0]         upd,
  output logic [NUM_COPIES*STEP_W-1:0]  steps,
  output logic [NUM_COPIES-2:0]         match
);

  for (genvar k = 0; k < NUM_COPIES; k++) begin : g_copy
    localparam int unsigned SLo = slice_lo(k, STATE_W);
    localparam int unsigned DLo = slice_lo(k, DIV_W);
    localparam int unsigned NLo = slice_lo(k, STEP_W);

    gnr_copy_slot #(
      .StateW(STATE_W),
      .DivW  (DIV_W),
      .StepW (STEP_W)
    ) u_slot (
      .clk_i       (clk),
      .rst_i       (rst),
      .reset_nos_i (reset_nos),
      .init_state_i(init_state),
      .start_i     (start_s[k]),
      .div_i       (div_cfg[DLo +: DIV_W]),
      .next_i      (next_in[SLo +: STATE_W]),
      .s_o         (s[SLo +: STATE_W]),
      .upd_o       (upd[k]),
      .steps_o     (steps[NLo +: STEP_W])
    );

    if (k > 0) begin : g_match
      assign match[k-1] = (s[SLo +: STATE_W] == s[STATE_W-1:0]);
    end
  end

  assign node_s = s;

endmodule

// File: tb/tb_gnr_node_param.sv
module tb_gnr_node_param;

  localparam int NC = 2;
  localparam int SW = 4;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          reset_nos;
  logic [SW-1:0] init_state;
  logic [1:0]    start_s;
  logic [3:0]    div_cfg;
  logic [7:0]    next_in;

  logic [7:0]  s, node_s, s2, node_s2;
  logic [1:0]  upd, upd2;
  logic [15:0] steps;
  logic [3:0]  steps2;
  logic [0:0]  match, match2;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural reference: per copy, state value, strobes seen since last load, total loads.
  int m_s[NC];
  int m_since[NC];
  int m_loads[NC];
  bit m_upd[NC];

  always #5 clk = ~clk;

  gnr_node_param #(.NUM_COPIES(2), .STATE_W(4), .DIV_W(2), .STEP_W(8)) dut (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
    .start_s(start_s), .div_cfg(div_cfg), .next_in(next_in),
    .s(s), .node_s(node_s), .upd(upd), .steps(steps), .match(match)
  );

  gnr_node_param #(.NUM_COPIES(2), .STATE_W(4), .DIV_W(2), .STEP_W(2)) dut_sat (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
    .start_s(start_s), .div_cfg(div_cfg), .next_in(next_in),
    .s(s2), .node_s(node_s2), .upd(upd2), .steps(steps2), .match(match2)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // After rst the divider count is 0, after reset_nos it equals D: a load needs count >= D.
  task automatic model_edge();
    for (int k = 0; k < NC; k++) begin
      int d;
      d = int'(div_cfg[k*DW +: DW]);
      m_upd[k] = 1'b0;
      if (rst) begin
        m_s[k] = 0; m_since[k] = 0; m_loads[k] = 0;
      end else if (reset_nos) begin
        m_s[k] = int'(init_state); m_since[k] = d; m_loads[k] = 0;
      end else if (start_s[k]) begin
        if (m_since[k] >= d) begin
          m_s[k] = int'(next_in[k*SW +: SW]);
          m_since[k] = 0;
          m_loads[k]++;
          m_upd[k] = 1'b1;
        end else begin
          m_since[k]++;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [7:0]  es;
    logic [1:0]  eu;
    logic [15:0] est;
    logic [3:0]  est2;
    for (int k = 0; k < NC; k++) begin
      es[k*SW +: SW]  = m_s[k][SW-1:0];
      eu[k]           = m_upd[k];
      est[k*8 +: 8]   = (m_loads[k] > 255) ? 8'd255 : m_loads[k][7:0];
      est2[k*2 +: 2]  = (m_loads[k] > 3) ? 2'd3 : m_loads[k][1:0];
    end
    chk("s", {8'd0, s}, {8'd0, es});
    chk("node_s", {8'd0, node_s}, {8'd0, es});
    chk("upd", {14'd0, upd}, {14'd0, eu});
    chk("steps", steps, est);
    chk("match", {15'd0, match}, {15'd0, (m_s[1] == m_s[0])});
    chk("s_sat", {8'd0, s2}, {8'd0, es});
    chk("steps_sat", {12'd0, steps2}, {12'd0, est2});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; reset_nos = 1'b0; init_state = '0; start_s = '0; div_cfg = '0; next_in = '0;
    tick();
    chk("rst_match_ones", {15'd0, match}, 16'd1);
    chk("rst_s_zero", {8'd0, s}, 16'd0);

    // D=(1,0): copy 1 divider 0, copy 0 divider 1; re-init with 5 then strobe both with 9.
    rst = 1'b0; div_cfg = {2'd0, 2'd1}; reset_nos = 1'b1; init_state = 4'd5;
    tick();
    chk("nos_init_55", {8'd0, s}, 16'h0055);
    reset_nos = 1'b0; start_s = 2'b11; next_in = 8'h99;
    tick();
    chk("first_strobe_loads_both", {8'd0, s}, 16'h0099);
    chk("first_strobe_upd", {14'd0, upd}, 16'd3);
    tick();
    chk("copy0_skips_second", {14'd0, upd}, 16'd2);
    tick();
    chk("copy0_loads_third", {14'd0, upd}, 16'd3);
    tick();

    // rst only, D0=2: first two strobes skipped, third loads 3.
    start_s = '0; rst = 1'b1;
    tick();
    rst = 1'b0; div_cfg = {2'd0, 2'd2}; start_s = 2'b01; next_in = 8'h03;
    tick();
    chk("d2_skip1", {8'd0, s}, 16'd0);
    tick();
    chk("d2_skip2", {8'd0, s}, 16'd0);
    tick();
    chk("d2_load3", {8'd0, s}, 16'h0003);
    chk("d2_upd_pulse", {14'd0, upd}, 16'd1);
    start_s = '0;
    tick();
    chk("d2_upd_once", {14'd0, upd}, 16'd0);

    // reset_nos together with strobes: strobe discarded.
    reset_nos = 1'b1; start_s = 2'b11; init_state = 4'hA; next_in = 8'h12;
    tick();
    chk("nos_with_strobe_s", {8'd0, s}, 16'h00AA);
    chk("nos_with_strobe_upd", {14'd0, upd}, 16'd0);
    chk("nos_with_strobe_steps", steps, 16'd0);

    // D=0, six strobes: 2-bit counters saturate at 3.
    reset_nos = 1'b0; div_cfg = '0;
    for (int i = 0; i < 6; i++) begin
      next_in = 8'(i * 17);
      tick();
      chk("sat_steps", {12'd0, steps2}, (i + 1 > 3) ? 16'h000F : 16'(((i + 1) << 2) | (i + 1)));
    end

    // D0 lowered from 3 to 0 while the count is 2: next strobe loads.
    start_s = '0; rst = 1'b1;
    tick();
    rst = 1'b0; div_cfg = {2'd0, 2'd3}; start_s = 2'b01; next_in = 8'h0E;
    tick();
    tick();
    chk("lower_d_pre", {8'd0, s}, 16'd0);
    div_cfg = '0;
    tick();
    chk("lower_d_loads", {8'd0, s}, 16'h000E);

    // match: both copies 7, then copy 1 reloaded with 4.
    start_s = 2'b11; next_in = 8'h77;
    tick();
    chk("match_eq", {15'd0, match}, 16'd1);
    start_s = 2'b10; next_in = 8'h47;
    tick();
    chk("match_ne", {15'd0, match}, 16'd0);

    // Randomised run against the reference model.
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 49) == 0);
      reset_nos  = ($urandom_range(0, 19) == 0);
      init_state = 4'($urandom);
      start_s    = 2'($urandom);
      next_in    = 8'($urandom);
      if ($urandom_range(0, 7) == 0) div_cfg = 4'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
